// File: rtl/seq_alu_if.sv
// Operation request and result/flag bundle between the CPU datapath and seq_alu.
// The master drives the request; the slave (ALU) drives busy/done, result and flags.
interface seq_alu_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [3:0]       select;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             zero;
    logic             neg;
    logic             carry;
    logic             ovf;
    logic             illegal;

    modport master (
        output start, select, data1, data2,
        input  busy, done, result, result_hi, zero, neg, carry, ovf, illegal
    );

    modport slave (
        input  start, select, data1, data2,
        output busy, done, result, result_hi, zero, neg, carry, ovf, illegal
    );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: logic/arith ops finish on the accepting edge, shifts take one cycle per bit,
// MUL is a WIDTH-step shift-add; start is ignored while busy, results and flags are registered.
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    seq_alu_if.slave   alu
);
    localparam int SAW = $clog2(WIDTH);
    localparam int CW  = SAW + 1;

    localparam logic [3:0] OP_FWD = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_SLL = 4'h6;
    localparam logic [3:0] OP_SRL = 4'h7;
    localparam logic [3:0] OP_SRA = 4'h8;
    localparam logic [3:0] OP_ROR = 4'h9;
    localparam logic [3:0] OP_MUL = 4'hA;

    typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             illegal_q, illegal_d;
    logic             done_q, done_d;

    logic             fin;
    logic [WIDTH-1:0] f_res;
    logic [WIDTH-1:0] f_hi;
    logic             f_carry;
    logic             f_ovf;
    logic             f_ill;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   madd;
    logic [WIDTH-1:0] sh;
    logic             sh_out;
    logic [SAW-1:0]   amt;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        mcand_d     = mcand_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        zero_d      = zero_q;
        neg_d       = neg_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        illegal_d   = illegal_q;
        done_d      = 1'b0;
        fin         = 1'b0;
        f_res       = '0;
        f_hi        = '0;
        f_carry     = 1'b0;
        f_ovf       = 1'b0;
        f_ill       = 1'b0;
        sum_ext     = '0;
        madd        = '0;
        sh          = '0;
        sh_out      = 1'b0;
        amt         = alu.data2[SAW-1:0];

        case (state_q)
            IDLE: begin
                if (alu.start) begin
                    case (alu.select)
                        OP_FWD: begin
                            fin   = 1'b1;
                            f_res = alu.data2;
                        end
                        OP_ADD: begin
                            sum_ext = {1'b0, alu.data1} + {1'b0, alu.data2};
                            fin     = 1'b1;
                            f_res   = sum_ext[WIDTH-1:0];
                            f_carry = sum_ext[WIDTH];
                            f_ovf   = (alu.data1[WIDTH-1] == alu.data2[WIDTH-1]) &&
                                      (sum_ext[WIDTH-1] != alu.data1[WIDTH-1]);
                        end
                        OP_SUB: begin
                            // Carry-out of a + ~b + 1 is the no-borrow flag.
                            sum_ext = {1'b0, alu.data1} + {1'b0, ~alu.data2} + (WIDTH+1)'(1);
                            fin     = 1'b1;
                            f_res   = sum_ext[WIDTH-1:0];
                            f_carry = sum_ext[WIDTH];
                            f_ovf   = (alu.data1[WIDTH-1] != alu.data2[WIDTH-1]) &&
                                      (sum_ext[WIDTH-1] != alu.data1[WIDTH-1]);
                        end
                        OP_AND: begin
                            fin   = 1'b1;
                            f_res = alu.data1 & alu.data2;
                        end
                        OP_OR: begin
                            fin   = 1'b1;
                            f_res = alu.data1 | alu.data2;
                        end
                        OP_XOR: begin
                            fin   = 1'b1;
                            f_res = alu.data1 ^ alu.data2;
                        end
                        OP_SLL, OP_SRL, OP_SRA, OP_ROR: begin
                            if (amt == '0) begin
                                fin   = 1'b1;
                                f_res = alu.data1;
                            end else begin
                                state_d = SHIFT;
                                op_d    = alu.select;
                                lo_d    = alu.data1;
                                cnt_d   = {1'b0, amt};
                            end
                        end
                        OP_MUL: begin
                            state_d = MUL;
                            mcand_d = alu.data1;
                            lo_d    = alu.data2;
                            hi_d    = '0;
                            cnt_d   = CW'(WIDTH);
                        end
                        default: begin
                            fin   = 1'b1;
                            f_ill = 1'b1;
                        end
                    endcase
                end
            end

            SHIFT: begin
                case (op_q)
                    OP_SLL: begin
                        sh     = {lo_q[WIDTH-2:0], 1'b0};
                        sh_out = lo_q[WIDTH-1];
                    end
                    OP_SRL: begin
                        sh     = {1'b0, lo_q[WIDTH-1:1]};
                        sh_out = lo_q[0];
                    end
                    OP_SRA: begin
                        sh     = {lo_q[WIDTH-1], lo_q[WIDTH-1:1]};
                        sh_out = lo_q[0];
                    end
                    default: begin
                        sh     = {lo_q[0], lo_q[WIDTH-1:1]};
                        sh_out = lo_q[0];
                    end
                endcase
                lo_d  = sh;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    fin     = 1'b1;
                    f_res   = sh;
                    f_carry = sh_out;
                end
            end

            MUL: begin
                // Product accumulates in {hi,lo}; the multiplier drains out of lo's LSB.
                madd    = lo_q[0] ? {1'b0, mcand_q} : '0;
                sum_ext = {1'b0, hi_q} + madd;
                hi_d    = sum_ext[WIDTH:1];
                lo_d    = {sum_ext[0], lo_q[WIDTH-1:1]};
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    fin     = 1'b1;
                    f_res   = lo_d;
                    f_hi    = hi_d;
                    f_carry = (hi_d != '0);
                end
            end

            default: state_d = IDLE;
        endcase

        if (fin) begin
            result_d    = f_res;
            result_hi_d = f_hi;
            zero_d      = ({f_hi, f_res} == '0);
            neg_d       = f_res[WIDTH-1];
            carry_d     = f_carry;
            ovf_d       = f_ovf;
            illegal_d   = f_ill;
            done_d      = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            op_q        <= '0;
            mcand_q     <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            illegal_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            mcand_q     <= mcand_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            illegal_q   <= illegal_d;
            done_q      <= done_d;
        end
    end

    assign alu.busy      = (state_q != IDLE);
    assign alu.done      = done_q;
    assign alu.result    = result_q;
    assign alu.result_hi = result_hi_q;
    assign alu.zero      = zero_q;
    assign alu.neg       = neg_q;
    assign alu.carry     = carry_q;
    assign alu.ovf       = ovf_q;
    assign alu.illegal   = illegal_q;
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=8): vector table plus reset, back-to-back, busy-ignore and abort sequences.
module tb_seq_alu;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(W)) bus ();
    seq_alu #(.WIDTH(W)) dut (.clk_i(clk), .rst_i(rst), .alu(bus));

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] sel;
        logic [7:0] d1;
        logic [7:0] d2;
        logic [7:0] res;
        logic [7:0] hi;
        logic [4:0] flags;   // {zero, neg, carry, ovf, illegal}
        int         lat;     // edges from acceptance up to and including the result edge
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] r, input logic [7:0] h, input logic [4:0] f,
                                input int l);
        vec_t v;
        v.sel = s; v.d1 = a; v.d2 = b; v.res = r; v.hi = h; v.flags = f; v.lat = l;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] flags_now();
        return {bus.zero, bus.neg, bus.carry, bus.ovf, bus.illegal};
    endfunction

    function automatic logic [22:0] all_out();
        return {bus.busy, bus.done, bus.result, bus.result_hi, bus.zero, bus.neg,
                bus.carry, bus.ovf, bus.illegal};
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        bus.start  = 1'b1;
        bus.select = v.sel;
        bus.data1  = v.d1;
        bus.data2  = v.d2;
        tick();
        bus.start  = 1'b0;
        bus.select = 4'h1;
        bus.data1  = ~v.d1;
        bus.data2  = ~v.d2;
        chk($sformatf("v%0d_busy_k", idx), bus.busy, (v.lat > 1));
        lat = 1;
        while (!bus.done && lat < 40) begin
            tick();
            lat++;
        end
        chk($sformatf("v%0d_latency", idx), lat, v.lat);
        chk($sformatf("v%0d_done", idx), bus.done, 1);
        chk($sformatf("v%0d_busy_done", idx), bus.busy, 0);
        chk($sformatf("v%0d_result", idx), bus.result, v.res);
        chk($sformatf("v%0d_result_hi", idx), bus.result_hi, v.hi);
        chk($sformatf("v%0d_flags", idx), flags_now(), v.flags);
        tick();
        chk($sformatf("v%0d_done_pulse", idx), bus.done, 0);
    endtask

    initial begin
        int lat;

        vecs.push_back(mk(4'h1, 8'h7F, 8'h01, 8'h80, 8'h00, 5'b01010, 1)); // ADD signed overflow
        vecs.push_back(mk(4'h2, 8'h05, 8'h05, 8'h00, 8'h00, 5'b10100, 1)); // SUB equal
        vecs.push_back(mk(4'h3, 8'hF0, 8'h3C, 8'h30, 8'h00, 5'b00000, 1)); // AND
        vecs.push_back(mk(4'h4, 8'hF0, 8'h0C, 8'hFC, 8'h00, 5'b01000, 1)); // OR
        vecs.push_back(mk(4'h5, 8'hFF, 8'h0F, 8'hF0, 8'h00, 5'b01000, 1)); // XOR
        vecs.push_back(mk(4'h0, 8'h12, 8'hA5, 8'hA5, 8'h00, 5'b01000, 1)); // FWD
        vecs.push_back(mk(4'h1, 8'hFF, 8'h01, 8'h00, 8'h00, 5'b10100, 1)); // ADD carry-out
        vecs.push_back(mk(4'h2, 8'h03, 8'h05, 8'hFE, 8'h00, 5'b01000, 1)); // SUB borrow
        vecs.push_back(mk(4'h2, 8'h80, 8'h01, 8'h7F, 8'h00, 5'b00110, 1)); // SUB overflow
        vecs.push_back(mk(4'h6, 8'h81, 8'h08, 8'h81, 8'h00, 5'b01000, 1)); // SLL amt=0 (masked)
        vecs.push_back(mk(4'hF, 8'h12, 8'h34, 8'h00, 8'h00, 5'b10001, 1)); // illegal 1111
        vecs.push_back(mk(4'hB, 8'hFF, 8'hFF, 8'h00, 8'h00, 5'b10001, 1)); // illegal 1011
        vecs.push_back(mk(4'h6, 8'h81, 8'h03, 8'h08, 8'h00, 5'b00000, 4)); // SLL 3
        vecs.push_back(mk(4'h8, 8'h80, 8'h02, 8'hE0, 8'h00, 5'b01000, 3)); // SRA 2
        vecs.push_back(mk(4'h9, 8'h01, 8'h01, 8'h80, 8'h00, 5'b01100, 2)); // ROR 1
        vecs.push_back(mk(4'h9, 8'h96, 8'h03, 8'hD2, 8'h00, 5'b01100, 4)); // ROR 3
        vecs.push_back(mk(4'h7, 8'h0F, 8'h04, 8'h00, 8'h00, 5'b10100, 5)); // SRL 4
        vecs.push_back(mk(4'h8, 8'h7F, 8'h07, 8'h00, 8'h00, 5'b10100, 8)); // SRA 7
        vecs.push_back(mk(4'h6, 8'h01, 8'h0F, 8'h80, 8'h00, 5'b01000, 8)); // SLL amt=7 (masked)
        vecs.push_back(mk(4'hA, 8'hFF, 8'hFF, 8'h01, 8'hFE, 5'b00100, 9)); // MUL max
        vecs.push_back(mk(4'hA, 8'h10, 8'h0F, 8'hF0, 8'h00, 5'b01000, 9)); // MUL fits low half
        vecs.push_back(mk(4'hA, 8'h00, 8'hAB, 8'h00, 8'h00, 5'b10000, 9)); // MUL zero
        vecs.push_back(mk(4'hA, 8'h80, 8'h02, 8'h00, 8'h01, 5'b00100, 9)); // MUL low half zero only

        // Reset held with a pending request: nothing may start.
        rst        = 1'b1;
        bus.start  = 1'b1;
        bus.select = 4'h1;
        bus.data1  = 8'h01;
        bus.data2  = 8'h01;
        tick();
        chk("reset_outputs_1", all_out(), 23'h0);
        tick();
        chk("reset_outputs_2", all_out(), 23'h0);
        rst       = 1'b0;
        bus.start = 1'b0;
        tick();
        chk("post_reset_idle", all_out(), 23'h0);

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // Back-to-back single-cycle ops keep DONE high for two cycles.
        bus.start = 1'b1; bus.select = 4'h1; bus.data1 = 8'h7F; bus.data2 = 8'h01;
        tick();
        chk("b2b_done_1", bus.done, 1);
        chk("b2b_result_1", bus.result, 8'h80);
        bus.select = 4'h3; bus.data1 = 8'hF0; bus.data2 = 8'h3C;
        tick();
        bus.start = 1'b0;
        chk("b2b_done_2", bus.done, 1);
        chk("b2b_result_2", bus.result, 8'h30);
        tick();
        chk("b2b_done_end", bus.done, 0);

        // Requests presented while a MUL is busy are dropped.
        bus.start = 1'b1; bus.select = 4'hA; bus.data1 = 8'hFF; bus.data2 = 8'hFF;
        tick();
        bus.select = 4'h1; bus.data1 = 8'h02; bus.data2 = 8'h03;
        lat = 1;
        while (!bus.done && lat < 40) begin
            if (lat == 7) bus.start = 1'b0;
            tick();
            lat++;
        end
        bus.start = 1'b0;
        chk("ign_latency", lat, 9);
        chk("ign_result", bus.result, 8'h01);
        chk("ign_result_hi", bus.result_hi, 8'hFE);
        tick();
        chk("ign_no_extra_done", bus.done, 0);
        chk("ign_idle", bus.busy, 0);

        // Reset in the 4th MUL cycle aborts without a DONE.
        bus.start = 1'b1; bus.select = 4'hA; bus.data1 = 8'hFF; bus.data2 = 8'hFF;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        chk("abort_busy_before", bus.busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_outputs", all_out(), 23'h0);
        tick();
        chk("abort_no_done_1", bus.done, 0);
        tick();
        chk("abort_no_done_2", all_out(), 23'h0);
        run_vec(mk(4'h1, 8'h02, 8'h03, 8'h05, 8'h00, 5'b00000, 1), 99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
